// File: rtl/score_pkg.sv
`default_nettype none
// score_pkg: glyph geometry, pixel values and the 10x11 digit bitmap table
// shared by the glyph writer and the digit-recognition path.
package score_pkg;

  localparam int GLYPH_W = 11;
  localparam logic [7:0] FG = 8'hFF;
  localparam logic [7:0] BG = 8'h00;

  typedef logic [3:0] digit_t;
  typedef logic [GLYPH_W-1:0] glyph_row_t;
  typedef glyph_row_t [GLYPH_W-1:0] glyph_t;
  typedef glyph_t [9:0] glyph_tab_t;

  // Row bit [GLYPH_W-1-col] holds pixel col, so literals read left to right.
  localparam glyph_row_t BAR = 11'b00111111100;
  localparam glyph_row_t LFT = 11'b00100000000;
  localparam glyph_row_t RGT = 11'b00000000100;

  // Seven-segment masks {a,b,c,d,e,f,g}, indexed by digit value.
  localparam logic [9:0][6:0] SEG = {
    7'b1111011, 7'b1111111, 7'b1110000, 7'b1011111, 7'b1011011,
    7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110
  };

  function automatic glyph_tab_t build_glyphs();
    glyph_tab_t t;
    logic [6:0] s;
    glyph_row_t up, lo;
    for (int d = 0; d < 10; d++) begin
      s  = SEG[d];
      up = (s[1] ? LFT : '0) | (s[5] ? RGT : '0);
      lo = (s[2] ? LFT : '0) | (s[4] ? RGT : '0);
      t[d][0]  = '0;
      t[d][1]  = s[6] ? BAR : up;
      t[d][2]  = up;
      t[d][3]  = up;
      t[d][4]  = up;
      t[d][5]  = s[0] ? BAR : (up | lo);
      t[d][6]  = lo;
      t[d][7]  = lo;
      t[d][8]  = lo;
      t[d][9]  = s[3] ? BAR : lo;
      t[d][10] = '0;
    end
    return t;
  endfunction

  localparam glyph_tab_t GLYPH_TAB = build_glyphs();

endpackage
`default_nettype wire

// File: rtl/score_glyph_rom.sv
`default_nettype none
// score_glyph_rom: combinational (digit, row) -> glyph row lookup; digits
// above 9 and rows past the cell read as all clear.
module score_glyph_rom
  import score_pkg::*;
(
  input  digit_t     digit_i,
  input  logic [3:0] row_i,
  output glyph_row_t row_o
);

  always_comb begin
    row_o = '0;
    if (digit_i <= 4'd9 && row_i < 4'(GLYPH_W)) begin
      row_o = GLYPH_TAB[digit_i][row_i];
    end
  end

endmodule
`default_nettype wire

// File: rtl/score_glyph_writer.sv
`default_nettype none
// score_glyph_writer: streams the 11x11 glyph pixels of NUM_DIGITS BCD digits
// onto a valid/ready write port. Optional: SCORE_LEADING_ZERO_BLANK_EN.
module score_glyph_writer
  import score_pkg::*;
#(
  parameter int NUM_DIGITS = 7,
  parameter int GAP        = 2,
  parameter int X_W        = 10,
  parameter int Y_W        = 9
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_i,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [X_W-1:0]          base_x_i,
  input  logic [Y_W-1:0]          base_y_i,
  output logic                    wr_valid_o,
  input  logic                    wr_ready_i,
  output logic [X_W-1:0]          wr_x_o,
  output logic [Y_W-1:0]          wr_y_o,
  output logic [7:0]              wr_data_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int P_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int C_W   = 4;
  localparam int PITCH = GLYPH_W + GAP;
  localparam logic [P_W-1:0] LAST_P  = P_W'(NUM_DIGITS - 1);
  localparam logic [C_W-1:0] LAST_RC = C_W'(GLYPH_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q;
  logic [4*NUM_DIGITS-1:0] digits_q;
  logic [X_W-1:0]          base_x_q;
  logic [Y_W-1:0]          base_y_q;
  logic [P_W-1:0]          cell_q, cell_d;
  logic [C_W-1:0]          row_q, row_d, col_q, col_d;
  logic                    wr_valid_q, busy_q, done_q;
  logic [X_W-1:0]          wr_x_q, wr_x_d;
  logic [Y_W-1:0]          wr_y_q, wr_y_d;
  logic [7:0]              wr_data_q, wr_data_d;

  logic [4*NUM_DIGITS-1:0] src_digits;
  logic [X_W-1:0]          src_x;
  logic [Y_W-1:0]          src_y;
  digit_t                  cur_digit;
  glyph_row_t              rom_row;
  logic                    blank;
  logic                    last_pix;
  logic                    zero_prefix;

  score_glyph_rom u_rom (
    .digit_i (cur_digit),
    .row_i   (row_d),
    .row_o   (rom_row)
  );

  // Next pixel: the first pixel of a new render while idle, otherwise the
  // successor of the one currently presented. Outputs are registered from it.
  always_comb begin
    src_digits  = (state_q == IDLE) ? digits_i : digits_q;
    src_x       = (state_q == IDLE) ? base_x_i : base_x_q;
    src_y       = (state_q == IDLE) ? base_y_i : base_y_q;
    cell_d      = cell_q;
    row_d       = row_q;
    col_d       = col_q;
    zero_prefix = 1'b1;
    blank       = 1'b0;
    if (state_q == IDLE) begin
      cell_d = '0;
      row_d  = '0;
      col_d  = '0;
    end else if (col_q == LAST_RC) begin
      col_d = '0;
      if (row_q == LAST_RC) begin
        row_d  = '0;
        cell_d = cell_q + 1'b1;
      end else begin
        row_d = row_q + 1'b1;
      end
    end else begin
      col_d = col_q + 1'b1;
    end

    cur_digit = src_digits[4*(NUM_DIGITS-1-int'(cell_d)) +: 4];

    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i <= int'(cell_d) && src_digits[4*(NUM_DIGITS-1-i) +: 4] != 4'd0) begin
        zero_prefix = 1'b0;
      end
    end
`ifdef SCORE_LEADING_ZERO_BLANK_EN
    blank = zero_prefix && (cell_d != LAST_P);
`else
    blank = 1'b0;
`endif

    wr_x_d    = src_x + X_W'(PITCH * int'(cell_d)) + X_W'(col_d);
    wr_y_d    = src_y + Y_W'(row_d);
    wr_data_d = (rom_row[LAST_RC - col_d] && !blank) ? FG : BG;
    last_pix  = (cell_q == LAST_P) && (row_q == LAST_RC) && (col_q == LAST_RC);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      digits_q   <= '0;
      base_x_q   <= '0;
      base_y_q   <= '0;
      cell_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      wr_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_x_q     <= '0;
      wr_y_q     <= '0;
      wr_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            state_q    <= EMIT;
            digits_q   <= digits_i;
            base_x_q   <= base_x_i;
            base_y_q   <= base_y_i;
            cell_q     <= cell_d;
            row_q      <= row_d;
            col_q      <= col_d;
            wr_x_q     <= wr_x_d;
            wr_y_q     <= wr_y_d;
            wr_data_q  <= wr_data_d;
            wr_valid_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        EMIT: begin
          if (wr_ready_i) begin
            if (last_pix) begin
              state_q    <= DONE;
              wr_valid_q <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              cell_q    <= cell_d;
              row_q     <= row_d;
              col_q     <= col_d;
              wr_x_q    <= wr_x_d;
              wr_y_q    <= wr_y_d;
              wr_data_q <= wr_data_d;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          wr_valid_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  assign wr_valid_o = wr_valid_q;
  assign wr_x_o     = wr_x_q;
  assign wr_y_o     = wr_y_q;
  assign wr_data_o  = wr_data_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_score_glyph_writer.sv
`default_nettype none
// tb_score_glyph_writer: scoreboard bench for the score glyph writer.
module tb_score_glyph_writer;
  import score_pkg::*;

  localparam int ND    = 7;
  localparam int PITCH = 13;
  localparam int CELLP = GLYPH_W * GLYPH_W;
  localparam int NPIX  = ND * CELLP;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [27:0] digits = '0;
  logic [9:0]  base_x = '0;
  logic [8:0]  base_y = '0;
  logic        wr_valid, wr_ready = 1'b0;
  logic [9:0]  wr_x;
  logic [8:0]  wr_y;
  logic [7:0]  wr_data;
  logic        busy, done;

  always #5 clk = ~clk;

  score_glyph_writer dut (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start),
    .digits_i   (digits),
    .base_x_i   (base_x),
    .base_y_i   (base_y),
    .wr_valid_o (wr_valid),
    .wr_ready_i (wr_ready),
    .wr_x_o     (wr_x),
    .wr_y_o     (wr_y),
    .wr_data_o  (wr_data),
    .busy_o     (busy),
    .done_o     (done)
  );

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [7:0] d;
  } pix_t;

  pix_t exp_q[$];
  pix_t obs_q[$];
  pix_t ref_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic pix_t model_pix(logic [27:0] dg, logic [9:0] bx, logic [8:0] by,
                                     int p, int r, int c);
    pix_t       px;
    logic [3:0] d;
    logic       blank;
    d     = dg[4*(ND-1-p) +: 4];
    blank = 1'b0;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
    if (p != ND-1) begin
      blank = 1'b1;
      for (int i = 0; i <= p; i++) if (dg[4*(ND-1-i) +: 4] != 4'd0) blank = 1'b0;
    end
`endif
    px.x = bx + 10'(p*PITCH + c);
    px.y = by + 9'(r);
    px.d = BG;
    if (!blank && d <= 4'd9) if (GLYPH_TAB[d][r][GLYPH_W-1-c]) px.d = FG;
    return px;
  endfunction

  function automatic int fg_in_cell(int p);
    int n = 0;
    for (int i = p*CELLP; i < (p+1)*CELLP && i < obs_q.size(); i++)
      if (obs_q[i].d != BG) n++;
    return n;
  endfunction

  task automatic drive_render(input logic [27:0] dg, input logic [9:0] bx,
                              input logic [8:0] by, input int ready_pct,
                              input int restart_at, input int reset_at);
    int   accepted = 0;
    int   cycles   = 0;
    int   last_acc = -10;
    bit   prev_stall = 0;
    bit   done_seen = 0;
    bit   reset_hit = 0;
    bit   saw_done;
    pix_t prev, cur, e;
    exp_q.delete();
    obs_q.delete();
    prev = '0;
    for (int p = 0; p < ND; p++)
      for (int r = 0; r < GLYPH_W; r++)
        for (int c = 0; c < GLYPH_W; c++)
          exp_q.push_back(model_pix(dg, bx, by, p, r, c));

    @(negedge clk);
    start = 1'b1; digits = dg; base_x = bx; base_y = by; wr_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; digits = ~dg; base_x = ~bx; base_y = ~by;
    n_checks++;
    if (busy !== 1'b1 || wr_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL start_latency: busy=%b wr_valid=%b, required 1 1", busy, wr_valid);
    end

    while (!done_seen && cycles < 20000) begin
      cur = {wr_x, wr_y, wr_data};
      if (prev_stall) begin
        n_checks++;
        if (cur !== prev || wr_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL stall_hold: got %h valid=%b, required %h valid=1", cur, wr_valid, prev);
        end
      end
      n_checks++;
      if (busy !== 1'b1) begin
        n_fail++;
        $display("FAIL busy_high: busy=%b at transfer %0d, required 1", busy, accepted);
      end
      if (done === 1'b1) begin
        done_seen = 1;
        n_checks++;
        if (accepted != NPIX || cycles != last_acc + 1 || wr_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL done_timing: transfers=%0d done_cycle=%0d last=%0d valid=%b, required %0d %0d 0",
                   accepted, cycles, last_acc, wr_valid, NPIX, last_acc + 1);
        end
        break;
      end
      if (!done_seen) begin
        n_checks++;
        if (wr_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL valid_high: wr_valid=%b at transfer %0d, required 1", wr_valid, accepted);
        end
      end
      if (reset_at >= 0 && accepted == reset_at) begin
        reset = 1'b1; start = 1'b0; wr_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (wr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_mid: valid=%b busy=%b done=%b, required 0 0 0", wr_valid, busy, done);
        end
        reset = 1'b0;
        saw_done = 0;
        repeat (30) begin
          @(negedge clk);
          if (done !== 1'b0 || wr_valid !== 1'b0) saw_done = 1;
        end
        n_checks++;
        if (saw_done) begin
          n_fail++;
          $display("FAIL reset_no_resume: done/valid seen=1, required 0");
        end
        reset_hit = 1;
        break;
      end
      start    = (restart_at >= 0 && accepted == restart_at);
      digits   = 28'h9999999;
      wr_ready = ($urandom_range(99) < ready_pct);
      if (wr_valid && wr_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL pixel_extra: got %h, required no transfer", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            n_fail++;
            $display("FAIL pixel[%0d]: got x=%0d y=%0d d=%h, required x=%0d y=%0d d=%h",
                     accepted, cur.x, cur.y, cur.d, e.x, e.y, e.d);
          end
        end
        obs_q.push_back(cur);
        accepted++;
        last_acc   = cycles;
        prev_stall = 0;
      end else begin
        prev_stall = wr_valid;
      end
      prev = cur;
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    wr_ready = 1'b0;

    if (!reset_hit) begin
      if (!done_seen) begin
        n_checks++;
        n_fail++;
        $display("FAIL render_timeout: transfers=%0d, required done after %0d", accepted, NPIX);
      end
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || wr_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL post_done: busy=%b done=%b valid=%b, required 0 0 0", busy, done, wr_valid);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (wr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        wr_x !== 10'd0 || wr_y !== 9'd0 || wr_data !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_values: valid=%b busy=%b done=%b x=%0d y=%0d d=%h, required all 0",
               wr_valid, busy, done, wr_x, wr_y, wr_data);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (wr_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: valid=%b busy=%b, required 0 0", wr_valid, busy);
    end
  endtask

  task automatic test_basic();
    drive_render(28'h0000123, 10'd100, 9'd50, 100, -1, -1);
    n_checks++;
    if (obs_q.size() != NPIX || obs_q[0].x !== 10'd100 || obs_q[0].y !== 9'd50) begin
      n_fail++;
      $display("FAIL first_pixel: size=%0d got (%0d,%0d), required (100,50)",
               obs_q.size(), obs_q[0].x, obs_q[0].y);
    end
    n_checks++;
    if (obs_q[6*CELLP].x !== 10'd178 || obs_q[6*CELLP].y !== 9'd50) begin
      n_fail++;
      $display("FAIL cell1_origin: got (%0d,%0d), required (178,50)",
               obs_q[6*CELLP].x, obs_q[6*CELLP].y);
    end
    n_checks++;
    if (obs_q[6*CELLP + 16].d !== 8'hFF || obs_q[6*CELLP].d !== 8'h00) begin
      n_fail++;
      $display("FAIL glyph3_topbar: got %h/%h, required ff/00",
               obs_q[6*CELLP + 16].d, obs_q[6*CELLP].d);
    end
    ref_q = obs_q;
  endtask

  task automatic test_stall();
    int diffs = 0;
    drive_render(28'h0000123, 10'd100, 9'd50, 50, -1, -1);
    for (int i = 0; i < NPIX; i++)
      if (i >= obs_q.size() || obs_q[i] !== ref_q[i]) diffs++;
    n_checks++;
    if (diffs != 0 || obs_q.size() != ref_q.size()) begin
      n_fail++;
      $display("FAIL stall_sequence: %0d differing pixels, size %0d, required 0 and %0d",
               diffs, obs_q.size(), ref_q.size());
    end
  endtask

  task automatic test_bad_digit();
    drive_render(28'h0000A23, 10'd0, 9'd0, 100, -1, -1);
    n_checks++;
    if (fg_in_cell(4) != 0) begin
      n_fail++;
      $display("FAIL nibble_A_blank: %0d FG pixels in cell 3, required 0", fg_in_cell(4));
    end
  endtask

  task automatic test_wrap();
    drive_render(28'h0000123, 10'h3F8, 9'd200, 100, -1, -1);
    n_checks++;
    if (obs_q[7].x !== 10'h3FF || obs_q[8].x !== 10'd0) begin
      n_fail++;
      $display("FAIL x_wrap: col7 x=%0d col8 x=%0d, required 1023 0", obs_q[7].x, obs_q[8].x);
    end
  endtask

  task automatic test_restart_reset();
    drive_render(28'h0000123, 10'd100, 9'd50, 100, 100, 300);
    drive_render(28'h0000456, 10'd20, 9'd30, 100, -1, -1);
  endtask

  task automatic test_leading_zero();
    drive_render(28'h0000000, 10'd0, 9'd0, 100, -1, -1);
    n_checks++;
    if (fg_in_cell(6) != 28) begin
      n_fail++;
      $display("FAIL zero_cell1: %0d FG pixels, required 28", fg_in_cell(6));
    end
`ifdef SCORE_LEADING_ZERO_BLANK_EN
    n_checks++;
    if (fg_in_cell(0) != 0 || fg_in_cell(5) != 0) begin
      n_fail++;
      $display("FAIL lz_blank_all0: cell7=%0d cell2=%0d FG, required 0 0", fg_in_cell(0), fg_in_cell(5));
    end
    drive_render(28'h0000123, 10'd0, 9'd0, 100, -1, -1);
    n_checks++;
    if (fg_in_cell(0) + fg_in_cell(1) + fg_in_cell(2) + fg_in_cell(3) != 0) begin
      n_fail++;
      $display("FAIL lz_blank_123: cells 7..4 have FG, required 0");
    end
`else
    n_checks++;
    if (fg_in_cell(0) != 28 || fg_in_cell(5) != 28) begin
      n_fail++;
      $display("FAIL literal_zero: cell7=%0d cell2=%0d FG, required 28 28", fg_in_cell(0), fg_in_cell(5));
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_bad_digit();
    test_wrap();
    test_restart_reset();
    test_leading_zero();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
